// File: rtl/mips_bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit counter encoding,
// the counter reset and allocate values, the BTB entry layout and the saturating update.
package mips_bp_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RST   = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Entry layout at the default geometry. The predictor declares its own copy
    // sized from its parameters, so an instance may be built with other widths.
    localparam int ENTRY_TAG_W = 8;
    localparam int ENTRY_XLEN  = 32;

    typedef struct packed {
        logic                   valid;
        logic [ENTRY_TAG_W-1:0] tag;
        logic [ENTRY_XLEN-1:0]  target;
        logic [1:0]             ctr;
    } bp_entry_t;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_perf_counters.sv
// Free-running branch and misprediction event counters; both wrap modulo 2^CNT_W.
module bp_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branchEvt,
    input  logic             mispredEvt,
    output logic [CNT_W-1:0] branches,
    output logic [CNT_W-1:0] mispredicts
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches    <= '0;
            mispredicts <= '0;
        end else begin
            if (branchEvt)  branches    <= branches + CNT_W'(1);
            if (mispredEvt) mispredicts <= mispredicts + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Branch predictor + BTB: combinational fetch lookup, decode-stage training and recovery.
// Optional gshare counter indexing is enabled with `define BP_GSHARE_EN.
module branch_predictor_btb
    import mips_bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  lk_pc,
    output logic             lk_hit,
    output logic             lk_taken,
    output logic [XLEN-1:0]  lk_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             upd_mispredict,
    output logic [XLEN-1:0]  upd_recover_pc,
    input  logic             flush_all,
`ifdef BP_GSHARE_EN
    output logic [IDX_W-1:0] lk_ghr,
    input  logic [IDX_W-1:0] upd_ghr,
`endif
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    // Counters live in their own array so gshare can index them apart from the BTB.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } btbEntry_t;

    btbEntry_t        btb    [ENTRIES];
    logic [1:0]       ctrTbl [ENTRIES];

    logic [IDX_W-1:0] lkIdx, updIdx, lkCtrIdx, updCtrIdx;
    logic [TAG_W-1:0] lkTag, updTag;
    logic             updHit;
    logic             unusedPcBits;

    assign lkIdx  = lk_pc[IDX_W+1:2];
    assign lkTag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign updIdx = upd_pc[IDX_W+1:2];
    assign updTag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unusedPcBits = ^{lk_pc, upd_pc};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    assign lkCtrIdx  = lkIdx ^ ghr;
    assign updCtrIdx = updIdx ^ upd_ghr;
    assign lk_ghr    = ghr;

    // A mispredict rewinds history to the instruction's snapshot plus its real outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ghr <= '0;
        else if (flush_all)      ghr <= '0;
        else if (upd_mispredict) ghr <= {upd_ghr[IDX_W-2:0], upd_taken};
        else if (lk_hit)         ghr <= {ghr[IDX_W-2:0], lk_taken};
    end
`else
    assign lkCtrIdx  = lkIdx;
    assign updCtrIdx = updIdx;
`endif

    assign lk_hit    = btb[lkIdx].valid && (btb[lkIdx].tag == lkTag);
    assign lk_taken  = lk_hit && ctrTbl[lkCtrIdx][1];
    assign lk_target = lk_taken ? btb[lkIdx].target : lk_pc + XLEN'(4);

    assign updHit         = btb[updIdx].valid && (btb[updIdx].tag == updTag);
    assign upd_mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                          (upd_taken && (upd_target != upd_pred_target)));
    assign upd_recover_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i]    <= '0;
                ctrTbl[i] <= CTR_RST;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) btb[i].valid <= 1'b0;
        end else if (upd_valid) begin
            if (updHit) begin
                ctrTbl[updCtrIdx] <= sat_ctr_next(ctrTbl[updCtrIdx], upd_taken);
                if (upd_taken) btb[updIdx].target <= upd_target;
            end else if (upd_taken) begin
                btb[updIdx]       <= '{valid: 1'b1, tag: updTag, target: upd_target};
                ctrTbl[updCtrIdx] <= CTR_ALLOC;
            end
        end
    end

    bp_perf_counters #(.CNT_W(CNT_W)) uPerf (
        .clk        (clk),
        .rst_n      (rst_n),
        .branchEvt  (upd_valid),
        .mispredEvt (upd_mispredict),
        .branches   (stat_branches),
        .mispredicts(stat_mispredicts)
    );

endmodule
